// File: rtl/uart_pkg.sv
// Shared definitions for the UART word transmitter slice.
package uart_pkg;

  // Serializer bit-phase states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned BYTES_PER_WORD       = 4;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 234;  // 27 MHz / 115200

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. byte_done flags the last cycle of the stop
// bit so the caller can issue the next load with no idle gap on the line.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       load,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        sh, sh_n;
  logic              tx_n;
  logic              last_tick;

  assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_done = (state == STOP) && last_tick;

  // State, counters and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic; tx is computed from the next state so it is registered.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    case (state)
      IDLE: begin
        if (load) begin
          state_n = START;
          cnt_n   = '0;
          sh_n    = byte_in;
        end
      end
      START: begin
        if (last_tick) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          cnt_n = '0;
          sh_n  = sh >> 1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          cnt_n = '0;
          if (load) begin
            state_n = START;
            sh_n    = byte_in;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 32-bit word as four back-to-back 8N1 bytes, LSB byte first.
// Optional: UART_WORD_TX_AUTO_EN starts a word whenever data_in differs
// from the last word sent.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  logic [31:0] word_sr;
  logic [1:0]  byte_idx;
  logic        byte_done;
  logic        trigger, accept, chain, finish, last_byte, load;
  logic [7:0]  byte_in;

`ifdef UART_WORD_TX_AUTO_EN
  logic [31:0] last_word;

  // Remembers the most recently accepted word for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_word <= '0;
    end else if (accept) begin
      last_word <= data_in;
    end
  end
`endif

  // Request decode and byte sequencing handshake with the serializer.
  always_comb begin
`ifdef UART_WORD_TX_AUTO_EN
    trigger = start || (data_in != last_word);
`else
    trigger = start;
`endif
    accept    = !busy && trigger;
    last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    chain     = busy && byte_done && !last_byte;
    finish    = busy && byte_done && last_byte;
    load      = accept || chain;
    // Byte 0 goes straight from data_in; later bytes come from the latch,
    // which holds only the bytes not yet handed to the serializer.
    byte_in   = accept ? data_in[7:0] : word_sr[7:0];
  end

  // Word latch, byte index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_sr  <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        word_sr  <= {8'h00, data_in[31:8]};
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (chain) begin
        word_sr  <= word_sr >> 8;
        byte_idx <= byte_idx + 2'd1;
      end else if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .byte_in  (byte_in),
    .load     (load),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Downstream consumer of the register file's debug tap: takes the 32-bit value of register x5 (`uart_data`) and transmits it over a UART TX line as four 8N1 bytes, least-significant byte first. It is the CPU's only console path: software writes x5, the core pulses `start`, and a host terminal receives the word. The block runs in the core clock domain and drives the FPGA TX pin directly.

## Interface
- `CLKS_PER_BIT`, default 234: core clock cycles per UART bit (27 MHz / 115200). Legal range is 2 or more.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  32  word to send; connected to the register file's `uart_data`.
- `start`  in  1  one-cycle request to send `data_in`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a word is in flight.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0. The FSM is in IDLE, the byte index is 0 and the bit counter is 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when `start`=1. On this transition, `data_in` is latched into a 32-bit shift register and the byte index is set to 0.
  - START: drives 0 for one bit time, then goes to DATA.
  - DATA: drives bits [0]..[7] of the current byte, LSB first, one bit time each, then goes to STOP.
  - STOP: drives 1 for one bit time.
    - If byte index < 3: increment the byte index and go to START.
    - If byte index = 3: pulse `done` and go to IDLE.
- Bit time is exactly `CLKS_PER_BIT` cycles. A counter runs 0..`CLKS_PER_BIT`-1 and wraps at the end of each bit.
- `start` while `busy`=1 is ignored. Requests are not queued.
- `data_in` changes after the latch do not affect the word in flight.
- `start` in the same cycle as `done` is ignored. The request is accepted only while in IDLE, and the FSM is still in STOP that cycle.
- `rst` mid-frame aborts the word. `tx` returns to 1 on the next edge and no `done` is produced.

## Timing
- `start` sampled high at edge N: `tx`=0 and `busy`=1 from edge N+1.
- One byte frame lasts 10×`CLKS_PER_BIT` cycles. One word lasts 40×`CLKS_PER_BIT` cycles.
- Back-to-back bytes: there is no idle gap. The next byte's start bit begins immediately after the previous stop bit.
- `done`=1 for exactly one cycle, at edge N+1+40×`CLKS_PER_BIT`. `busy` falls at that same edge.
- Earliest accepted new `start` is at the edge after `done`.
- All outputs are registered. There is no combinational path from any input to `tx`.

## Configuration
- `UART_WORD_TX_AUTO_EN`
  - Defined: a 32-bit register holds the last word sent (reset value 0). In IDLE, `data_in` ≠ that register triggers a transmission exactly as if `start` had been pulsed. Debug prints then need no core handshake.
  - Undefined: only `start` triggers a transmission. The comparison register is not built.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3);
  - `BYTES_PER_WORD`=4;
  - `DATA_BITS`=8;
  - the default `CLKS_PER_BIT`.
- Natural sub-module: `uart_tx_byte`, a single-byte 8N1 serializer.
  - Ports: `clk`, `rst`, `byte_in[7:0]`, `load`, `tx`, `byte_done`.
  - The top level sequences four loads and owns `busy`, `done` and the word latch.

## Test plan
Bench uses `CLKS_PER_BIT`=4.
- Reset: hold `rst` 3 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- Basic word: `data_in`=0x12345678, `start` pulse → line decodes bytes 0x78, 0x56, 0x34, 0x12 in order. Each frame is 40 cycles, the word is 160 cycles, and `done` comes 161 cycles after `start`.
- Ignored start: pulse `start` again at cycle 50 with `data_in`=0xFFFFFFFF → the transmitted word is still 0x12345678 and only one `done` occurs.
- Latch isolation: change `data_in` to 0x0 one cycle after `start` → the line still carries 0xDEADBEEF if that was the value latched.
- Mid-frame reset: assert `rst` at cycle 70 → `tx`=1 and `busy`=0 next cycle. No `done`, and the next `start` sends a full, clean word.
- `UART_WORD_TX_AUTO_EN` defined: set `data_in` 0→0xA5, with no `start` → one word 0x000000A5 is sent. Holding 0xA5 triggers no further transmission.
